// File: rtl/rifl_pkg.sv
// Shared frame-level types and constants for the TX frame path.
package rifl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      FC   = 2'd2,
      COMP = 2'd3
   } frame_type_t;

   // FC payload layout: only the pause bit is meaningful, the rest is zero
   localparam int FC_PAUSE_BIT = 0;

endpackage

// File: rtl/sat_updown_cntr.sv
// Saturating up/down counter with a sticky overflow flag and a synchronous clear.
module sat_updown_cntr #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX = '1;

   // clr leaves ovf alone so an overflow stays visible until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         if (cnt == MAX) ovf <= 1'b1;
         else            cnt <= cnt + WIDTH'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Per-slot frame source selection: compensation debt first, then flow control,
// then user data, then idle fill.
module tx_frame_scheduler
   import rifl_pkg::*;
#(
   parameter int DWIDTH    = 256,
   parameter int FC_PERIOD = 64,
   parameter int OWE_WIDTH = 5
) (
   input  logic                 tx_frame_clk,
   input  logic                 rst_n,
   input  logic                 clock_active,
   input  logic                 compensate,
   input  logic                 fc_pause,
   input  logic                 remote_pause,
   input  logic [DWIDTH-1:0]    s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [DWIDTH-1:0]    frame_data,
   output logic [1:0]           frame_type,
   output logic                 frame_last,
   output logic                 frame_vld,
   input  logic                 frame_rdy,
   output logic [OWE_WIDTH-1:0] owe_cnt,
   output logic                 comp_ovf
);

   localparam int TW = (FC_PERIOD > 2) ? $clog2(FC_PERIOD) : 1;
   localparam logic [TW-1:0] TMAX = TW'(FC_PERIOD - 1);

   typedef enum logic {PKT_IDLE, PKT_BODY} pkt_state_t;

   pkt_state_t        pkt_state, pkt_next;
   frame_type_t       sel, type_q;
   logic              slot_open, comp_load, fc_load, fc_set;
   logic              fc_pend, fc_pause_q, last_q, vld_q;
   logic [TW-1:0]     timer, timer_nxt;
   logic [DWIDTH-1:0] data_q, payload;

   assign slot_open = clock_active && (!vld_q || frame_rdy);

   always_comb begin
      sel = IDLE;
      if (owe_cnt != '0)
         sel = COMP;
      else if (fc_pend)
         sel = FC;
      else if (s_axis_tvalid && (pkt_state == PKT_BODY || !remote_pause))
         sel = DATA;
   end

   assign s_axis_tready = slot_open && (sel == DATA);
   assign comp_load     = slot_open && (sel == COMP);
   assign fc_load       = slot_open && (sel == FC);

   always_comb begin
      payload = '0;
      if (sel == DATA) payload = s_axis_tdata;
      if (sel == FC)   payload[FC_PAUSE_BIT] = fc_pause;
   end

   // timer parks at its terminal value while the FC frame waits behind COMP
   always_comb begin
      timer_nxt = timer;
      if (fc_load)            timer_nxt = '0;
      else if (timer != TMAX) timer_nxt = timer + TW'(1);
   end

   assign fc_set = (fc_pause != fc_pause_q) || (timer_nxt == TMAX);

   // remote_pause only gates the start of a packet, never its continuation
   always_comb begin
      pkt_next = pkt_state;
      if (!clock_active)
         pkt_next = PKT_IDLE;
      else if (s_axis_tready)
         pkt_next = s_axis_tlast ? PKT_IDLE : PKT_BODY;
   end

   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) pkt_state <= PKT_IDLE;
      else        pkt_state <= pkt_next;
   end

   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         fc_pend    <= 1'b0;
         fc_pause_q <= 1'b0;
         timer      <= '0;
         vld_q      <= 1'b0;
         type_q     <= IDLE;
         data_q     <= '0;
         last_q     <= 1'b0;
      end else begin
         fc_pause_q <= fc_pause;
         if (!clock_active) begin
            fc_pend <= 1'b0;
            timer   <= '0;
            vld_q   <= 1'b0;
         end else begin
            timer <= timer_nxt;
            if (fc_set)       fc_pend <= 1'b1;
            else if (fc_load) fc_pend <= 1'b0;
            if (slot_open) begin
               vld_q  <= 1'b1;
               type_q <= sel;
               data_q <= payload;
               last_q <= (sel == DATA) && s_axis_tlast;
            end
         end
      end
   end

   sat_updown_cntr #(.WIDTH(OWE_WIDTH)) u_owe (
      .clk   (tx_frame_clk),
      .rst_n (rst_n),
      .clr   (!clock_active),
      .inc   (compensate),
      .dec   (comp_load),
      .cnt   (owe_cnt),
      .ovf   (comp_ovf)
   );

   assign frame_data = data_q;
   assign frame_type = type_q;
   assign frame_last = last_q;
   assign frame_vld  = vld_q;

endmodule
